// File: rtl/core_pass_ctrl.sv
// Sequences the core instruction word through one kernel-position (kij) pass.
// Optional: define CORE_PASS_CTRL_OVLP_RD_EN to drain the OFIFO while EXE is still running.
module core_pass_ctrl #(
   parameter int col        = 8,
   parameter int row        = 8,
   parameter int len_nij    = 36,
   parameter int w_base     = 1024,
   parameter int gap_cycles = 10,
   parameter int drain_max  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  kij_idx,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        busy,
   output logic        done,
   output logic        err_timeout
);

   localparam int M1    = (col + row > gap_cycles) ? col + row : gap_cycles;
   localparam int M2    = (len_nij > drain_max) ? len_nij : drain_max;
   localparam int CMAX  = (M1 > M2) ? M1 : M2;
   localparam int CNT_W = $clog2(CMAX) + 1;
   localparam int M_W   = $clog2(len_nij + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_KRD, S_KFL, S_KLD, S_GAP, S_ARD, S_AFL, S_EXE, S_DRN, S_ORD, S_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [M_W-1:0]     r_q, r_d, m_q, m_d;
   logic [3:0]         kij_q, kij_d;
   logic               err_d, busy_d, done_d;
   logic               rd_d, wr_d, rd_win;
   logic [33:0]        inst_d;
   logic [10:0]        pbase;

   assign pbase = 11'(kij_q) * 11'(len_nij);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         r_q         <= '0;
         m_q         <= '0;
         kij_q       <= '0;
         inst        <= 34'h1_800C_0000;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         m_q         <= m_d;
         kij_q       <= kij_d;
         inst        <= inst_d;
         busy        <= busy_d;
         done        <= done_d;
         err_timeout <= err_d;
      end
   end

   // Next state and phase counter; outputs below are decoded from the next
   // state so each registered word lines up with the state it belongs to.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      kij_d   = kij_q;
      err_d   = err_timeout;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = S_KRD;
               kij_d   = kij_idx;
               err_d   = 1'b0;
            end
         end
         S_KRD: if (cnt_q == CNT_W'(col - 1)) begin
            state_d = S_KFL;
            cnt_d   = '0;
         end
         S_KFL: begin
            state_d = S_KLD;
            cnt_d   = '0;
         end
         S_KLD: if (cnt_q == CNT_W'(col + row - 1)) begin
            state_d = S_GAP;
            cnt_d   = '0;
         end
         S_GAP: if (cnt_q == CNT_W'(gap_cycles - 1)) begin
            state_d = S_ARD;
            cnt_d   = '0;
         end
         S_ARD: if (cnt_q == CNT_W'(len_nij - 1)) begin
            state_d = S_AFL;
            cnt_d   = '0;
         end
         S_AFL: begin
            state_d = S_EXE;
            cnt_d   = '0;
         end
         S_EXE: if (cnt_q == CNT_W'(len_nij - 1)) begin
            cnt_d = '0;
`ifdef CORE_PASS_CTRL_OVLP_RD_EN
            // r counts issued reads, so it also covers a write still in flight
            if (m_q == M_W'(len_nij))
               state_d = S_FIN;
            else if (r_q != '0)
               state_d = S_ORD;
            else
               state_d = S_DRN;
`else
            state_d = S_DRN;
`endif
         end
         S_DRN: begin
            if (ofifo_valid) begin
               state_d = S_ORD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(drain_max - 1)) begin
               state_d = S_FIN;
               cnt_d   = '0;
               err_d   = 1'b1;
            end
         end
         S_ORD: if (m_q == M_W'(len_nij)) state_d = S_FIN;
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
`ifdef CORE_PASS_CTRL_OVLP_RD_EN
      rd_win = (state_d == S_ORD) || (state_d == S_EXE);
`else
      rd_win = (state_d == S_ORD);
`endif
      rd_d = rd_win && ofifo_valid && (r_q != M_W'(len_nij));
      // pmem write trails the OFIFO read by one cycle
      wr_d = inst[6];
      if (state_q == S_IDLE) begin
         r_d = '0;
         m_d = '0;
      end else begin
         r_d = r_q + M_W'(rd_d);
         m_d = m_q + M_W'(wr_d);
      end

      inst_d     = '0;
      inst_d[32] = 1'b1;
      inst_d[31] = 1'b1;
      inst_d[19] = 1'b1;
      inst_d[18] = 1'b1;
      case (state_d)
         S_KRD: begin
            inst_d[19]   = 1'b0;
            inst_d[17:7] = 11'(w_base) + 11'(cnt_d);
         end
         S_ARD: begin
            inst_d[19]   = 1'b0;
            inst_d[17:7] = 11'(cnt_d);
         end
         S_KLD: begin
            inst_d[3] = 1'b1;
            inst_d[0] = 1'b1;
         end
         S_EXE: begin
            inst_d[3] = 1'b1;
            inst_d[1] = 1'b1;
         end
         default: ;
      endcase
      // SRAM read data arrives one cycle after the read enable
      inst_d[2] = ~inst[19];
      inst_d[6] = rd_d;
      if (wr_d) begin
         inst_d[32]    = 1'b0;
         inst_d[31]    = 1'b0;
         inst_d[30:20] = pbase + 11'(m_q);
      end
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FIN);
   end

endmodule

// File: tb/tb_core_pass_ctrl.sv
// Directed bench for core_pass_ctrl: kernel fetch, reset, drains, timeout, 9-pass sweep.
module tb_core_pass_ctrl;

   logic        clk = 1'b0;
   logic        reset, start, ofifo_valid;
   logic [3:0]  kij_idx;
   logic [33:0] inst;
   logic        busy, done, err_timeout;

   localparam logic [33:0] RST_INST = 34'h1_800C_0000;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, done_n = 0, bad_addr = 0;
   int wr_addr[$];
   int wr_cyc[$];
   int cov[324];
   bit cov_en = 0;

   always #5 clk = ~clk;

   core_pass_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .kij_idx(kij_idx),
      .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done),
      .err_timeout(err_timeout)
   );

   // pmem write and done observer
   always @(negedge clk) begin
      cyc++;
      if (!reset) begin
         if (!inst[32] && !inst[31]) begin
            wr_addr.push_back(int'(inst[30:20]));
            wr_cyc.push_back(cyc);
            if (cov_en) begin
               if (inst[30:20] < 11'd324) cov[inst[30:20]]++;
               else bad_addr++;
            end
         end
         if (done) done_n++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic pulse_start(input logic [3:0] k);
      start   = 1'b1;
      kij_idx = k;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Returns at the first sample after EXE (first DRN cycle)
   task automatic wait_exe_end(input bit poke);
      bit seen = 0;
      bit ok = 0;
      for (int c = 0; c < 400; c++) begin
         if (poke && c == 50) begin
            start   = 1'b1;
            kij_idx = 4'd7;
         end else start = 1'b0;
         if (poke && c == 51) chk("busy_after_ignored_start", busy, 1);
         if (inst[1]) seen = 1;
         else if (seen) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("exe_end_seen", ok, 1);
   endtask

   task automatic run_pass(input logic [3:0] k, input bit gap, input bit poke);
      bit ok = 0;
      pulse_start(k);
      chk("busy_on_start", busy, 1);
      chk("err_clear_on_start", err_timeout, 0);
      wait_exe_end(poke);
      repeat (4) @(negedge clk);
      ofifo_valid = 1'b1;
      if (gap) begin
         repeat (10) @(negedge clk);
         ofifo_valid = 1'b0;
         repeat (4) @(negedge clk);
         ofifo_valid = 1'b1;
         repeat (26) @(negedge clk);
      end else repeat (36) @(negedge clk);
      ofifo_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (done) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("done_seen", ok, 1);
      @(negedge clk);
   endtask

   task automatic check_writes(input string tag, input int base, input int gap_at);
      int bad_a = 0, bad_c = 0;
      chk({tag, "_wr_count"}, wr_addr.size(), 36);
      for (int k = 0; k < wr_addr.size(); k++) begin
         if (wr_addr[k] != base + k) bad_a++;
         if (k > 0 && (wr_cyc[k] - wr_cyc[k-1]) != ((k == gap_at) ? 5 : 1)) bad_c++;
      end
      chk({tag, "_addr_seq_errs"}, bad_a, 0);
      chk({tag, "_timing_errs"}, bad_c, 0);
      chk({tag, "_done_pulses"}, done_n, 1);
      chk({tag, "_busy_after"}, busy, 0);
   endtask

   initial begin
      int rd_n, l0_n, l0_first, ld_n, ld_first, cov_bad;
      reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; kij_idx = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_inst", inst, RST_INST);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err_timeout, 0);
      reset = 1'b0;
      @(negedge clk);

      // kernel fetch timing
      rd_n = 0; l0_n = 0; l0_first = -1; ld_n = 0; ld_first = -1;
      pulse_start(4'd0);
      for (int c = 0; c <= 30; c++) begin
         if (c < 8) chk("kfetch_addr", inst[17:7], 1024 + c);
         if (!inst[19]) rd_n++;
         if (inst[2]) begin
            if (l0_n == 0) l0_first = c;
            l0_n++;
         end
         if (inst[0]) begin
            if (ld_n == 0) ld_first = c;
            ld_n++;
         end
         @(negedge clk);
      end
      chk("kfetch_reads", rd_n, 8);
      chk("kfetch_l0wr_cycles", l0_n, 8);
      chk("kfetch_l0wr_first", l0_first, 1);
      chk("kfetch_load_cycles", ld_n, 16);
      chk("kfetch_load_first", ld_first, 9);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset in the middle of kernel load
      pulse_start(4'd2);
      repeat (15) @(negedge clk);
      chk("kld_load_high", inst[0], 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_inst", inst, RST_INST);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      // full pass kij=3
      wr_addr.delete(); wr_cyc.delete(); done_n = 0;
      run_pass(4'd3, 1'b0, 1'b0);
      check_writes("full", 108, -1);

      // pass with ofifo_valid gap after 10 reads
      wr_addr.delete(); wr_cyc.delete(); done_n = 0;
      run_pass(4'd5, 1'b1, 1'b0);
      check_writes("gap", 180, 10);

      // drain timeout
      wr_addr.delete(); wr_cyc.delete(); done_n = 0;
      pulse_start(4'd1);
      wait_exe_end(1'b0);
      repeat (63) @(negedge clk);
      chk("to_err_before", err_timeout, 0);
      chk("to_done_before", done, 0);
      @(negedge clk);
      chk("to_err_set", err_timeout, 1);
      chk("to_done_pulse", done, 1);
      chk("to_busy_fin", busy, 1);
      @(negedge clk);
      chk("to_done_low", done, 0);
      chk("to_busy_low", busy, 0);
      chk("to_err_sticky", err_timeout, 1);
      chk("to_no_writes", wr_addr.size(), 0);
      chk("to_idle_inst", inst, RST_INST);

      // nine back-to-back passes, one start poked mid-ARD
      for (int i = 0; i < 324; i++) cov[i] = 0;
      cov_en = 1;
      for (int k = 0; k < 9; k++) run_pass(4'(k), 1'b0, k == 4);
      cov_en = 0;
      cov_bad = 0;
      for (int i = 0; i < 324; i++) if (cov[i] != 1) cov_bad++;
      chk("sweep_cov_errs", cov_bad, 0);
      chk("sweep_out_of_range", bad_addr, 0);
      chk("sweep_final_busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
